wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file. It merges two result streams into the single regfile write port (write_ce/write_addr/write_data):
  - the single-cycle pipeline result;
  - a long-latency unit result (divider/load) using a valid/ready handshake.
- It keeps a pending-register scoreboard for long-latency destinations and drives hazard and bypass signals back to decode.
- It forces a pipeline bubble when the long-latency unit is starved.

Parameters:
- STARVE_MAX, 4, consecutive cycles lu_valid may wait unserved before pipe_stall asserts (range 1..15).
- SP_INIT, 32'h2000_7000, informational only; this block does not initialise registers.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pipe_wb_en  in  1  pipeline result valid this cycle (never back-pressured)
- pipe_wb_addr  in  5  pipeline destination register
- pipe_wb_data  in  32  pipeline result
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  combinational; accept long-latency result this cycle
- lu_addr  in  5  long-latency destination register
- lu_data  in  32  long-latency result
- issue_lu  in  1  decode issues a long-latency op this cycle
- issue_rd  in  5  destination of the issued op
- dec_rs1  in  5  decode source 1
- dec_rs2  in  5  decode source 2
- dec_rd  in  5  decode destination
- hazard  out  1  combinational; a decode operand or destination is pending
- byp1_hit  out  1  combinational; dec_rs1 matches the in-flight write
- byp2_hit  out  1  combinational; dec_rs2 matches the in-flight write
- byp_data  out  32  combinational; equals write_data
- pipe_stall  out  1  registered; pipeline must insert a bubble (pipe_wb_en low) next cycle
- busy_vec  out  32  registered scoreboard, bit n set = xn pending; bit 0 is always 0
- write_ce  out  1  registered regfile write enable
- write_addr  out  5  registered regfile write address
- write_data  out  32  registered regfile write data

Behaviour:
- Reset (async, rst_n low): write_ce=0, write_addr=0, write_data=0, busy_vec=0, pipe_stall=0, starve counter=0, state=IDLE. Combinational outputs follow from these values.
- Arbitration:
  - lu_ready = lu_valid & ~pipe_wb_en.
  - Pipeline has absolute priority.
  - The handshake completes when lu_valid & lu_ready.
- Output register, 1-cycle latency. At posedge:
  - If pipe_wb_en: capture the pipe address/data.
  - Else if the LU handshake completes: capture the LU address/data.
  - write_ce = (selected source valid) & (address != 0). Writes to x0 are dropped, but an LU handshake to x0 still completes.
  - write_addr/write_data hold their last value when write_ce=0.
- Bypass:
  - byp1_hit = write_ce & (write_addr == dec_rs1) & (dec_rs1 != 0). byp2_hit is the same for dec_rs2.
  - Regfile reads are combinational and the update lands at the end of the cycle, so decode must take byp_data on a hit.
- Scoreboard, per bit n from 1 to 31:
  - Set when issue_lu & issue_rd==n.
  - Cleared when an LU handshake completes with lu_addr==n.
  - Set and clear of the same n in the same cycle: set wins.
  - issue_rd==0 sets nothing.
- hazard = busy_vec[dec_rs1] | busy_vec[dec_rs2] | busy_vec[dec_rd], with index 0 always clear. It uses the registered busy_vec only; an issue in the current cycle does not raise hazard until the next cycle.
- Starvation FSM:
  - IDLE -> WAIT when lu_valid & pipe_wb_en; counter=1.
  - WAIT: if the handshake completes, or lu_valid drops, -> IDLE with counter=0.
  - WAIT: else counter++; when counter reaches STARVE_MAX -> FORCE and pipe_stall=1.
  - FORCE: pipe_stall held at 1. Once the handshake completes -> IDLE and pipe_stall=0 at the same edge.
  - If pipe_wb_en is still high during FORCE (protocol violation), the pipeline still wins and the FSM stays in FORCE.
- Reset mid-operation: any pending writeback is lost and write_ce drops immediately (asynchronous); the scoreboard is cleared.

Test Plan:
- Pipe only: pipe_wb_en=1, addr=5, data=0xDEADBEEF -> next cycle write_ce=1, write_addr=5, write_data=0xDEADBEEF; with dec_rs1=5 in that cycle, byp1_hit=1.
- Collision: pipe (addr 3, data 0x11) and LU (addr 7, data 0x22) valid together -> lu_ready=0, regfile write x3=0x11. Next cycle with pipe idle -> lu_ready=1, then write x7=0x22.
- Scoreboard: issue_lu, rd=9 -> busy_vec=0x200 next cycle; dec_rs2=9 gives hazard=1. LU handshake on addr 9 -> busy_vec=0 the following edge. Issue rd=9 in the same cycle as that handshake -> bit 9 stays set.
- Starvation: lu_valid=1 and pipe_wb_en=1 held -> pipe_stall=1 after STARVE_MAX=4 edges. Drop pipe_wb_en -> handshake completes, pipe_stall=0 the same edge.
- x0: LU handshake with addr 0, data 0xFFFFFFFF -> write_ce stays 0, lu_ready=1; issue_rd=0 leaves busy_vec=0.
- Async reset: assert rst_n=0 between edges while busy_vec=0x80 and write_ce=1 -> both clear immediately without a clock edge.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback merge of the single-cycle pipeline result and a
// long-latency (valid/ready) result into the single regfile write port.
// It also keeps the pending-destination scoreboard, drives hazard/bypass
// information to decode, and forces a pipeline bubble when the long-latency
// unit has waited too long.
module wb_arbiter #(
    parameter int          STARVE_MAX = 4,
    parameter logic [31:0] SP_INIT    = 32'h2000_7000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_wb_en,
    input  logic [4:0]  pipe_wb_addr,
    input  logic [31:0] pipe_wb_data,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    input  logic        issue_lu,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    output logic        hazard,
    output logic        byp1_hit,
    output logic        byp2_hit,
    output logic [31:0] byp_data,
    output logic        pipe_stall,
    output logic [31:0] busy_vec,
    output logic        write_ce,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data
);

    // The starvation counter is 4 bits wide, so the limit must fit in 1..15.
    // SP_INIT only documents the stack pointer reset value used elsewhere;
    // it is checked for word alignment so a bad override is caught early.
    if (STARVE_MAX < 1 || STARVE_MAX > 15 || SP_INIT[1:0] != 2'b00) begin : g_param_check
        $error("wb_arbiter: STARVE_MAX must be 1..15 and SP_INIT word aligned");
    end

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FORCE = 2'd2;

    logic [1:0]  state;
    logic [3:0]  starve_cnt;
    logic [3:0]  starve_cnt_inc;
    logic        lu_hs;
    logic        sel_valid;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;
    logic        write_fire;
    logic [31:0] busy_set;
    logic [31:0] busy_clr;
    logic [31:0] busy_next;

    // The pipeline can never be held off, so the long-latency unit only gets
    // the port in cycles where the pipeline has nothing to write.
    assign lu_ready = lu_valid & ~pipe_wb_en;
    assign lu_hs    = lu_valid & lu_ready;

    // Source select for the write port: pipeline first, then a completed LU handshake.
    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = lu_addr;
        sel_data  = lu_data;
        if (pipe_wb_en) begin
            sel_valid = 1'b1;
            sel_addr  = pipe_wb_addr;
            sel_data  = pipe_wb_data;
        end else if (lu_hs) begin
            sel_valid = 1'b1;
        end
    end

    // x0 is hardwired to zero, so a write to it is dropped (the LU handshake
    // itself still completes through lu_ready).
    assign write_fire = sel_valid & (sel_addr != 5'd0);

    // Registered regfile write port; address/data only move on a real write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_ce   <= 1'b0;
            write_addr <= 5'd0;
            write_data <= 32'd0;
        end else begin
            write_ce <= write_fire;
            if (write_fire) begin
                write_addr <= sel_addr;
                write_data <= sel_data;
            end
        end
    end

    // The regfile update lands at the end of the cycle, so the value sitting in
    // the write register is what decode must use when it names that register.
    assign byp_data = write_data;
    assign byp1_hit = write_ce & (write_addr == dec_rs1) & (dec_rs1 != 5'd0);
    assign byp2_hit = write_ce & (write_addr == dec_rs2) & (dec_rs2 != 5'd0);

    // Scoreboard next state: a new issue wins over a same-cycle retirement.
    always_comb begin
        busy_set = 32'd0;
        busy_clr = 32'd0;
        if (issue_lu) begin
            busy_set[issue_rd] = 1'b1;
        end
        if (lu_hs) begin
            busy_clr[lu_addr] = 1'b1;
        end
        busy_next = ((busy_vec & ~busy_clr) | busy_set) & ~32'd1;
    end

    // Scoreboard register of long-latency destinations still outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec <= 32'd0;
        end else begin
            busy_vec <= busy_next;
        end
    end

    // Only the registered scoreboard is consulted; bit 0 is never set.
    assign hazard = busy_vec[dec_rs1] | busy_vec[dec_rs2] | busy_vec[dec_rd];

    assign starve_cnt_inc = starve_cnt + 4'd1;

    // Starvation tracker: counts cycles the LU result waits behind the
    // pipeline and requests a bubble once the limit is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            starve_cnt <= 4'd0;
            pipe_stall <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (lu_valid & pipe_wb_en) begin
                        starve_cnt <= 4'd1;
                        if (STARVE_LIM == 4'd1) begin
                            state      <= S_FORCE;
                            pipe_stall <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (lu_hs | ~lu_valid) begin
                        state      <= S_IDLE;
                        starve_cnt <= 4'd0;
                    end else begin
                        starve_cnt <= starve_cnt_inc;
                        if (starve_cnt_inc == STARVE_LIM) begin
                            state      <= S_FORCE;
                            pipe_stall <= 1'b1;
                        end
                    end
                end
                S_FORCE: begin
                    // A pipeline write here is a protocol violation; it still
                    // wins the port and the bubble request stays up.
                    if (lu_hs) begin
                        state      <= S_IDLE;
                        starve_cnt <= 4'd0;
                        pipe_stall <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    starve_cnt <= 4'd0;
                    pipe_stall <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: table of single-cycle vectors plus hand-written
// sequences for starvation and asynchronous reset.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        pipe_wb_en;
    logic [4:0]  pipe_wb_addr;
    logic [31:0] pipe_wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        issue_lu;
    logic [4:0]  issue_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        hazard;
    logic        byp1_hit;
    logic        byp2_hit;
    logic [31:0] byp_data;
    logic        pipe_stall;
    logic [31:0] busy_vec;
    logic        write_ce;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    int errors = 0;
    int checks = 0;

    wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_wb_en(pipe_wb_en), .pipe_wb_addr(pipe_wb_addr), .pipe_wb_data(pipe_wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
        .issue_lu(issue_lu), .issue_rd(issue_rd),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .hazard(hazard), .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp_data(byp_data),
        .pipe_stall(pipe_stall), .busy_vec(busy_vec),
        .write_ce(write_ce), .write_addr(write_addr), .write_data(write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        il;
        logic [4:0]  ir;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [3:0]  e_comb;   // {lu_ready, hazard, byp1_hit, byp2_hit} before the edge
        logic        e_ce;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [31:0] e_busy;
        logic        e_stall;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(
        input logic pe, input logic [4:0] pa, input logic [31:0] pd,
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic il, input logic [4:0] ir,
        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
        input logic [3:0] ecomb, input logic ce, input logic [4:0] wa,
        input logic [31:0] wd, input logic [31:0] busy, input logic stall);
        vec_t v;
        v.pe = pe; v.pa = pa; v.pd = pd;
        v.lv = lv; v.la = la; v.ld = ld;
        v.il = il; v.ir = ir;
        v.r1 = r1; v.r2 = r2; v.rd = rd;
        v.e_comb = ecomb; v.e_ce = ce; v.e_wa = wa; v.e_wd = wd;
        v.e_busy = busy; v.e_stall = stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pipe_wb_en = v.pe; pipe_wb_addr = v.pa; pipe_wb_data = v.pd;
        lu_valid = v.lv; lu_addr = v.la; lu_data = v.ld;
        issue_lu = v.il; issue_rd = v.ir;
        dec_rs1 = v.r1; dec_rs2 = v.r2; dec_rd = v.rd;
    endtask

    task automatic idle_inputs();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        //                pe pa  pd            lv la  ld            il ir  r1  r2  rd   comb     ce wa  wd            busy          st
        vecs[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        0, 0,  0,  0,  0,  4'b0000, 1, 5,  32'hDEADBEEF, 32'h0,        0);
        vecs[1]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  5,  0,  0,  4'b0010, 0, 5,  32'hDEADBEEF, 32'h0,        0);
        vecs[2]  = mk(1, 3,  32'h11,       1, 7,  32'h22,       0, 0,  0,  0,  0,  4'b0000, 1, 3,  32'h11,       32'h0,        0);
        vecs[3]  = mk(0, 0,  32'h0,        1, 7,  32'h22,       0, 0,  0,  3,  0,  4'b1001, 1, 7,  32'h22,       32'h0,        0);
        vecs[4]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 9,  0,  9,  0,  4'b0000, 0, 7,  32'h22,       32'h200,      0);
        vecs[5]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0,  9,  0,  4'b0100, 0, 7,  32'h22,       32'h200,      0);
        vecs[6]  = mk(0, 0,  32'h0,        1, 9,  32'h99,       0, 0,  9,  0,  0,  4'b1100, 1, 9,  32'h99,       32'h0,        0);
        vecs[7]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 9,  0,  0,  9,  4'b0000, 0, 9,  32'h99,       32'h200,      0);
        vecs[8]  = mk(0, 0,  32'h0,        1, 9,  32'hAA,       1, 9,  0,  0,  9,  4'b1100, 1, 9,  32'hAA,       32'h200,      0);
        vecs[9]  = mk(0, 0,  32'h0,        1, 9,  32'hBB,       0, 0,  9,  0,  0,  4'b1110, 1, 9,  32'hBB,       32'h0,        0);
        vecs[10] = mk(0, 0,  32'h0,        1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,  0,  4'b1000, 0, 9,  32'hBB,       32'h0,        0);
        vecs[11] = mk(1, 0,  32'h12345678, 0, 0,  32'h0,        0, 0,  0,  0,  0,  4'b0000, 0, 9,  32'hBB,       32'h0,        0);
        vecs[12] = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 31, 0,  0,  0,  4'b0000, 0, 9,  32'hBB,       32'h80000000, 0);
        vecs[13] = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 7,  31, 0,  0,  4'b0100, 0, 9,  32'hBB,       32'h80000080, 0);
        vecs[14] = mk(0, 0,  32'h0,        1, 31, 32'h31,       0, 0,  7,  0,  0,  4'b1100, 1, 31, 32'h31,       32'h80,       0);

        // Reset state
        #12;
        chk("reset write_ce", {31'd0, write_ce}, 32'd0);
        chk("reset write_addr", {27'd0, write_addr}, 32'd0);
        chk("reset write_data", write_data, 32'd0);
        chk("reset busy_vec", busy_vec, 32'd0);
        chk("reset pipe_stall", {31'd0, pipe_stall}, 32'd0);
        chk("reset comb", {28'd0, lu_ready, hazard, byp1_hit, byp2_hit}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d comb rdy/haz/b1/b2", i),
                {28'd0, lu_ready, hazard, byp1_hit, byp2_hit}, {28'd0, vecs[i].e_comb});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d write_ce", i), {31'd0, write_ce}, {31'd0, vecs[i].e_ce});
            chk($sformatf("v%0d write_addr", i), {27'd0, write_addr}, {27'd0, vecs[i].e_wa});
            chk($sformatf("v%0d write_data", i), write_data, vecs[i].e_wd);
            chk($sformatf("v%0d byp_data", i), byp_data, vecs[i].e_wd);
            chk($sformatf("v%0d busy_vec", i), busy_vec, vecs[i].e_busy);
            chk($sformatf("v%0d pipe_stall", i), {31'd0, pipe_stall}, {31'd0, vecs[i].e_stall});
        end

        // Starvation: pipe and LU both valid, stall rises on the 4th edge
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(mk(1, 1, 32'h100 + 32'(i), 1, 2, 32'h55, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
            #1;
            chk($sformatf("starve%0d lu_ready", i), {31'd0, lu_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("starve%0d pipe_stall", i), {31'd0, pipe_stall}, (i >= 3) ? 32'd1 : 32'd0);
            chk($sformatf("starve%0d write_data", i), write_data, 32'h100 + 32'(i));
        end
        @(negedge clk);
        pipe_wb_en = 1'b0;
        #1;
        chk("force lu_ready", {31'd0, lu_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("force release pipe_stall", {31'd0, pipe_stall}, 32'd0);
        chk("force release write_ce", {31'd0, write_ce}, 32'd1);
        chk("force release write_addr", {27'd0, write_addr}, 32'd2);
        chk("force release write_data", write_data, 32'h55);
        chk("force release busy_vec", busy_vec, 32'h80);

        // LU valid drops while waiting: counter restarts, no stall
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(mk(1, 1, 32'h200, (i < 2) ? 1'b1 : 1'b0, 2, 32'h55, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
            chk($sformatf("drop%0d pipe_stall", i), {31'd0, pipe_stall}, 32'd0);
        end

        // Asynchronous reset between edges
        @(negedge clk);
        drive(mk(1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("pre-reset write_ce", {31'd0, write_ce}, 32'd1);
        chk("pre-reset busy_vec", busy_vec, 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset write_ce", {31'd0, write_ce}, 32'd0);
        chk("async reset busy_vec", busy_vec, 32'd0);
        chk("async reset write_addr", {27'd0, write_addr}, 32'd0);
        chk("async reset write_data", write_data, 32'd0);
        chk("async reset pipe_stall", {31'd0, pipe_stall}, 32'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset write_ce", {31'd0, write_ce}, 32'd0);
        chk("post-reset busy_vec", busy_vec, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
